// File: rtl/ram_port_arbiter.sv
// Two-port arbiter for a single-port RAM: fixed priority to port 0 with a starvation
// limit that forces a port-1 grant. Each transfer runs IDLE -> ACCESS -> CAPTURE.
module ram_port_arbiter #(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  we0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  output logic                  ack0,
  output logic [DATA_WIDTH-1:0] rdata0,
  input  logic                  req1,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  ack1,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  busy
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE} state_t;

  state_t        state;
  logic          owner;
  logic          is_write;
  logic [CW-1:0] starve_cnt;
  logic          pick1;

  // Port 1 wins when alone or when port 0 has starved it for the full limit.
  assign pick1 = req1 && (!req0 || (starve_cnt == LIMIT));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      owner      <= 1'b0;
      is_write   <= 1'b0;
      starve_cnt <= '0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      rdata0     <= '0;
      rdata1     <= '0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      busy       <= 1'b0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            owner     <= pick1;
            ram_we    <= pick1 ? we1 : we0;
            is_write  <= pick1 ? we1 : we0;
            ram_addr  <= pick1 ? addr1 : addr0;
            ram_wdata <= pick1 ? wdata1 : wdata0;
            busy      <= 1'b1;
            state     <= ACCESS;
            if (pick1 || !req1)
              starve_cnt <= '0;
            else if (starve_cnt != LIMIT)
              starve_cnt <= starve_cnt + CW'(1);
          end
        end
        ACCESS: begin
          ram_we <= 1'b0;
          state  <= CAPTURE;
        end
        CAPTURE: begin
          // ram_rdata now reflects the address presented during ACCESS.
          if (!is_write) begin
            if (owner) rdata1 <= ram_rdata;
            else       rdata0 <= ram_rdata;
          end
          if (owner) ack1 <= 1'b1;
          else       ack0 <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          ram_we <= 1'b0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter: directed transfers push expected acks and RAM
// writes into queues; monitors on the falling edge pop and compare them.
module tb_ram_port_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, we0, req1, we1;
  logic [7:0] addr0, wdata0, addr1, wdata1;
  logic       ack0, ack1;
  logic [7:0] rdata0, rdata1;
  logic       ram_we;
  logic [7:0] ram_addr, ram_wdata, ram_rdata;
  logic       busy;

  typedef struct {
    bit         port;
    bit         is_read;
    logic [7:0] data;
  } ack_exp_t;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_exp_t;

  ack_exp_t   sb[$];
  wr_exp_t    wq[$];
  logic [7:0] mem [256];
  logic [7:0] model_rdata0 = 8'h00;
  logic [7:0] model_rdata1 = 8'h00;
  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  int         grant_cycle = 0;
  bit         prev_busy = 1'b0;
  bit         ok;

  ram_port_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Synchronous-read RAM: data for an address appears the cycle after it is presented.
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Cycle k ends at edge k; a grant at edge N makes ACCESS cycle N+1 and the ack cycle N+3.
  always @(negedge clk) begin
    int cur;
    ack_exp_t e;
    wr_exp_t w;
    cur = cyc + 1;
    if (busy && !prev_busy) grant_cycle = cur - 1;
    prev_busy = busy;
    if (ram_we) begin
      if (wq.size() == 0) begin
        check_output("unexpected_ram_we", 32'(ram_we), 32'd0);
      end else begin
        w = wq.pop_front();
        check_output("ram_write_addr", 32'(ram_addr), 32'(w.addr));
        check_output("ram_write_data", 32'(ram_wdata), 32'(w.data));
      end
    end
    if (ack0 || ack1) begin
      check_output("ack_onehot", 32'(ack0 && ack1), 32'd0);
      if (sb.size() == 0) begin
        check_output("unexpected_ack", 32'({ack1, ack0}), 32'd0);
      end else begin
        e = sb.pop_front();
        check_output("ack_port", 32'(ack1), 32'(e.port));
        check_output("ack_latency", 32'(cur - grant_cycle), 32'd3);
        if (e.is_read) begin
          if (e.port) model_rdata1 = e.data;
          else        model_rdata0 = e.data;
        end
        check_output("rdata0", 32'(rdata0), 32'(model_rdata0));
        check_output("rdata1", 32'(rdata1), 32'(model_rdata1));
      end
    end
  end

  task automatic wait_grant(output bit found);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clk); #1;
      if (busy) found = 1'b1;
    end
    if (!found) check_output("grant_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_ack(output bit found);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clk); #1;
      if (ack0 || ack1) found = 1'b1;
    end
    if (!found) check_output("ack_timeout", 32'd0, 32'd1);
  endtask

  // One transfer on one port; req is dropped the cycle after the grant.
  task automatic apply_stimulus(input bit port, input bit we, input logic [7:0] addr,
                                input logic [7:0] wdata, input logic [7:0] exp_data);
    bit found;
    sb.push_back('{port, !we, exp_data});
    if (we) wq.push_back('{addr, wdata});
    if (port) begin req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wdata; end
    else      begin req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wdata; end
    wait_grant(found);
    if (found) begin
      check_output("access_addr", 32'(ram_addr), 32'(addr));
      check_output("access_we", 32'(ram_we), 32'(we));
    end
    req0 = 1'b0;
    req1 = 1'b0;
    wait_ack(found);
  endtask

  initial begin
    int ack_cyc [3];
    bit pattern [10];
    for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    mem[8'h12] <= 8'hA5;
    mem[8'h01] <= 8'h11;
    mem[8'h02] <= 8'h22;
    mem[8'h03] <= 8'h33;
    rst = 1'b0;
    req0 = 1'b0; we0 = 1'b0; addr0 = 8'h00; wdata0 = 8'h00;
    req1 = 1'b0; we1 = 1'b0; addr1 = 8'h00; wdata1 = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check_output("reset_busy", 32'(busy), 32'd0);
    check_output("reset_acks", 32'({ack1, ack0}), 32'd0);
    check_output("reset_ram_we", 32'(ram_we), 32'd0);
    check_output("reset_ram_addr", 32'(ram_addr), 32'd0);
    check_output("reset_ram_wdata", 32'(ram_wdata), 32'd0);
    check_output("reset_rdata", 32'({rdata1, rdata0}), 32'd0);
    rst = 1'b1;

    // Reset during ACCESS of a write: ram_we falls at once, no ack, no RAM update.
    @(posedge clk); #1;
    req1 = 1'b1; we1 = 1'b1; addr1 = 8'h80; wdata1 = 8'h99;
    wait_grant(ok);
    check_output("abort_we_before", 32'(ram_we), 32'd1);
    rst = 1'b0;
    #1;
    check_output("abort_we_async", 32'(ram_we), 32'd0);
    check_output("abort_busy_async", 32'(busy), 32'd0);
    req1 = 1'b0; we1 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check_output("abort_idle_busy", 32'(busy), 32'd0);
    check_output("abort_no_write", 32'(mem[8'h80]), 32'd0);

    apply_stimulus(1'b0, 1'b0, 8'h12, 8'h00, 8'hA5);
    apply_stimulus(1'b1, 1'b1, 8'hFF, 8'h3C, 8'h00);
    check_output("mem_ff", 32'(mem[8'hFF]), 32'h3C);
    apply_stimulus(1'b0, 1'b1, 8'h40, 8'h7E, 8'h00);
    apply_stimulus(1'b1, 1'b0, 8'h40, 8'h00, 8'h7E);

    // Back-to-back reads: a new address is presented in each ack cycle.
    sb.push_back('{1'b0, 1'b1, 8'h11});
    sb.push_back('{1'b0, 1'b1, 8'h22});
    sb.push_back('{1'b0, 1'b1, 8'h33});
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h01;
    for (int i = 0; i < 3; i++) begin
      wait_ack(ok);
      ack_cyc[i] = cyc;
      if (i < 2) addr0 = 8'(i + 2);
      else       req0 = 1'b0;
    end
    check_output("b2b_gap1", 32'(ack_cyc[1] - ack_cyc[0]), 32'd3);
    check_output("b2b_gap2", 32'(ack_cyc[2] - ack_cyc[1]), 32'd3);

    // Contention with both requests held: grant order 0,0,0,0,1,0,0,0,0,1.
    pattern = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    for (int i = 0; i < 10; i++)
      sb.push_back('{pattern[i], 1'b1, pattern[i] ? 8'h3C : 8'hA5});
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h12;
    req1 = 1'b1; we1 = 1'b0; addr1 = 8'hFF;
    for (int i = 0; i < 10; i++) wait_ack(ok);
    req0 = 1'b0;
    req1 = 1'b0;

    repeat (6) @(posedge clk);
    #1;
    check_output("sb_drained", 32'(sb.size()), 32'd0);
    check_output("wq_drained", 32'(wq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
